piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out transmitter for the FSM-D datapath: reads a WIDTH-bit word out of a
//  loaded datapath register and shifts it out one bit per accepted beat.
//  Valid/ready handshake on both sides: the parallel side takes one word at a time; the
//  serial side honours downstream backpressure. Control FSM plus shift/count datapath.
// PARAMETERS
//  WIDTH      8  bits per word; legal range WIDTH >= 2
//  MSB_FIRST  1  1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      upstream word available on in_data
//  in_ready   out  1      serializer can accept a word this cycle
//  in_data    in   WIDTH  parallel word; sampled only on an in_valid & in_ready cycle
//  ser_out    out  1      current serial bit
//  ser_valid  out  1      ser_out holds a valid bit
//  ser_ready  in   1      downstream accepts ser_out this cycle
//  ser_last   out  1      current bit is the final bit of the word
//  busy       out  1      word in flight (state != IDLE)
// BEHAVIOUR
//  Reset (rst=1, async): state=IDLE, shift reg=0, bit count=0.
//   Outputs during and after reset: in_ready=1, ser_valid=0, ser_out=0, ser_last=0, busy=0.
//  States:
//   IDLE  : in_ready=1, ser_valid=0. On in_valid=1 at a clk edge: shreg<=in_data, cnt<=0 -> SHIFT.
//   SHIFT : in_ready=0, ser_valid=1, busy=1.
//           ser_out = shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
//           ser_last = (cnt == WIDTH-1).
//           On ser_ready=1: shreg shifts one place toward the output end and zero-fills; cnt<=cnt+1.
//           On ser_ready=1 with ser_last=1: shreg not shifted, cnt<=0 -> IDLE.
//  Latency: first bit is valid on the cycle after the accepting edge.
//   Word occupancy = 1 + WIDTH + stall cycles; no bubble between bits while ser_ready stays high.
//  Backpressure: ser_ready=0 holds ser_out, ser_last, shreg and cnt unchanged; ser_valid stays 1.
//  Back-to-back words: in_ready is 0 for the whole of SHIFT. Minimum spacing is WIDTH+1 cycles
//   (one IDLE cycle between words). in_valid in SHIFT is ignored and not captured.
//  cnt width is $clog2(WIDTH). cnt never exceeds WIDTH-1; no wrap-around arithmetic is relied on.
//  ser_out in IDLE is 0. ser_out, ser_last and in_ready decode from registered state only;
//   no combinational path from in_valid or ser_ready to any output.
//  rst mid-word: the word is abandoned, no further bits are sent, and all outputs return to
//   reset values asynchronously.
//  X on in_data is never sampled outside a handshake cycle.
// STRUCTURE
//  Package piso_pkg: typedef enum logic {IDLE, SHIFT} piso_state_t.
//  FSM: two-block (state register + next-state/output decode). Shift register and counter are
//   inline datapath registers, each with async clear on rst and enable decoded by the FSM.
//  Sub-module bit_counter #(WIDTH): en, clr, cnt, at_max (cnt==WIDTH-1). Instantiated once.
// TESTING
//  1. Reset check: rst pulse mid-cycle (async) -> outputs at reset values immediately
//     (in_ready=1, ser_valid=0, ser_out=0, busy=0).
//  2. WIDTH=8, MSB_FIRST=1, ser_ready=1, load 8'hA5 -> bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles.
//     ser_last=1 only on the 8th bit; in_ready=1 again on the next cycle.
//  3. MSB_FIRST=0, load 8'h01 -> first bit 1, then seven 0s.
//  4. Backpressure: load 8'hF0 -> ser_ready=0 for 3 cycles after the 2nd bit; bit 2 is held
//     stable with ser_valid=1; the full sequence is unchanged; total occupancy is 12 cycles.
//  5. Back-to-back: hold in_valid=1 with 8'hFF then 8'h00 -> second word accepted exactly one
//     IDLE cycle after the first word's ser_last beat; in_data changes during SHIFT are ignored.
//  6. Reset mid-word: rst after 3 bits of 8'h3C -> ser_valid=0 at once.
//     Next load 8'h81 serializes cleanly (1,0,0,0,0,0,0,1).

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types for the parallel-in/serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Bit position counter for the serializer: synchronous clear wins over increment.
module bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     at_max
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready on both sides.
// Every output decodes from registered state, so there is no input-to-output path.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);
    localparam int CNT_W   = $clog2(WIDTH);
    localparam int OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CNT_W-1:0] bit_cnt;
    logic             at_max;
    logic             load;
    logic             shift;
    logic             cnt_en;
    logic             cnt_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // The final bit is not shifted out of the register; the word is simply retired.
                if (ser_ready) begin
                    if (at_max) begin
                        cnt_clr = 1'b1;
                        state_d = IDLE;
                    end else begin
                        shift  = 1'b1;
                        cnt_en = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else if (load) begin
            shreg_q <= in_data;
        end else if (shift) begin
            shreg_q <= shreg_shifted;
        end
    end

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .en     (cnt_en),
        .clr    (cnt_clr),
        .cnt    (bit_cnt),
        .at_max (at_max)
    );

    // The shift register keeps the last bit after a word retires, so gate ser_out on state.
    assign busy      = (state_q == SHIFT);
    assign in_ready  = (state_q == IDLE);
    assign ser_valid = busy;
    assign ser_out   = busy & shreg_q[OUT_IDX];
    assign ser_last  = busy & (bit_cnt == CNT_W'(WIDTH - 1));

endmodule
